warp_line_coalescer: RTL and testbench

- Sits directly downstream of the accumulation warp looper and consumes its addrval stream: id, per-lane addresses, lane valid mask and retire flag.
- Merges the VSIZE lane addresses of one warp into memory-line requests, one request per distinct line, issued over consecutive cycles.
- Each request carries the lanes it serves and each lane's word offset within the line; it feeds the read/write memory request path.

---
 rtl/warp_line_coalescer.sv | 119 +++++++++++
 tb/tb_warp_line_coalescer.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/warp_line_coalescer.sv
// Coalesces one warp's per-lane word addresses into one memory-line request per distinct line.
// Define COALESCE_STAT_EN to add saturating vector/line counters (o_stat_vecs, o_stat_lines).
module warp_line_coalescer #(
  parameter int VSIZE   = 32,
  parameter int ABW     = 32,
  parameter int NCFG_BW = 3,
  parameter int LINE_BW = 3,
  parameter int LBW     = ABW - LINE_BW
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     addrval_rdy,
  output logic                     addrval_ack,
  input  logic [NCFG_BW-1:0]       i_id,
  input  logic [ABW*VSIZE-1:0]     i_address,
  input  logic [VSIZE-1:0]         i_valid,
  input  logic                     i_retire,
  output logic                     line_rdy,
  input  logic                     line_ack,
  output logic [NCFG_BW-1:0]       o_id,
  output logic [LBW-1:0]           o_line_addr,
  output logic [VSIZE-1:0]         o_lane_mask,
  output logic [LINE_BW*VSIZE-1:0] o_word_sel,
  output logic                     o_retire,
  output logic                     o_last
`ifdef COALESCE_STAT_EN
  ,
  output logic [15:0]              o_stat_vecs,
  output logic [15:0]              o_stat_lines
`endif
);

  localparam int LW = (VSIZE > 1) ? $clog2(VSIZE) : 1;

  logic                 busy_q;
  logic [NCFG_BW-1:0]   id_q;
  logic [ABW*VSIZE-1:0] addr_q;
  logic                 retire_q;
  logic [VSIZE-1:0]     pend_q;

  logic [LBW-1:0]   line_of [VSIZE];
  logic [LW-1:0]    leader;
  logic             found;
  logic [LBW-1:0]   lead_line;
  logic [VSIZE-1:0] match;
  logic             last;
  logic             accept;
  logic             take;

  for (genvar g = 0; g < VSIZE; g++) begin : g_lane
    assign line_of[g] = addr_q[g*ABW+LINE_BW +: LBW];
    assign o_word_sel[g*LINE_BW +: LINE_BW] = addr_q[g*ABW +: LINE_BW];
    assign match[g] = pend_q[g] && (line_of[g] == lead_line);
  end

  // Leader is the lowest pending lane; requests therefore come out in ascending lane order.
  always_comb begin
    leader = '0;
    found  = 1'b0;
    for (int i = 0; i < VSIZE; i++) begin
      if (pend_q[i] && !found) begin
        leader = LW'(i);
        found  = 1'b1;
      end
    end
  end

  // An empty retiring vector has no leader and reports line 0.
  assign lead_line   = found ? line_of[leader] : '0;
  assign last        = busy_q && (match == pend_q);
  assign line_rdy    = busy_q;
  assign o_id        = id_q;
  assign o_line_addr = busy_q ? lead_line : '0;
  assign o_lane_mask = busy_q ? match : '0;
  assign o_last      = last;
  assign o_retire    = retire_q && last;

  assign take        = busy_q && line_ack;
  assign accept      = addrval_rdy && (!busy_q || (line_ack && last));
  assign addrval_ack = accept;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      busy_q   <= 1'b0;
      id_q     <= '0;
      addr_q   <= '0;
      retire_q <= 1'b0;
      pend_q   <= '0;
    end else if (accept) begin
      busy_q   <= (i_valid != '0) || i_retire;
      id_q     <= i_id;
      addr_q   <= i_address;
      retire_q <= i_retire;
      pend_q   <= i_valid;
    end else if (take) begin
      pend_q <= pend_q & ~match;
      if (last) busy_q <= 1'b0;
    end
  end

`ifdef COALESCE_STAT_EN
  logic [15:0] vecs_q;
  logic [15:0] lines_q;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      vecs_q  <= '0;
      lines_q <= '0;
    end else begin
      if (accept && (vecs_q != 16'hFFFF)) vecs_q <= vecs_q + 16'd1;
      if (take && (lines_q != 16'hFFFF)) lines_q <= lines_q + 16'd1;
    end
  end

  assign o_stat_vecs  = vecs_q;
  assign o_stat_lines = lines_q;
`endif

endmodule

// File: tb/tb_warp_line_coalescer.sv
// Randomized self-checking bench for warp_line_coalescer against a queue-based line-grouping model.
module tb_warp_line_coalescer;
  localparam int VS  = 32;
  localparam int AB  = 32;
  localparam int NB  = 3;
  localparam int LB  = 3;
  localparam int LBW = AB - LB;

  logic               i_clk = 1'b0;
  logic               i_rst = 1'b0;
  logic               addrval_rdy = 1'b0;
  logic               addrval_ack;
  logic [NB-1:0]      i_id = '0;
  logic [AB*VS-1:0]   i_address = '0;
  logic [VS-1:0]      i_valid = '0;
  logic               i_retire = 1'b0;
  logic               line_rdy;
  logic               line_ack = 1'b0;
  logic [NB-1:0]      o_id;
  logic [LBW-1:0]     o_line_addr;
  logic [VS-1:0]      o_lane_mask;
  logic [LB*VS-1:0]   o_word_sel;
  logic               o_retire;
  logic               o_last;
`ifdef COALESCE_STAT_EN
  logic [15:0]        o_stat_vecs;
  logic [15:0]        o_stat_lines;
`endif

  warp_line_coalescer dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .addrval_rdy(addrval_rdy), .addrval_ack(addrval_ack),
    .i_id(i_id), .i_address(i_address), .i_valid(i_valid), .i_retire(i_retire),
    .line_rdy(line_rdy), .line_ack(line_ack),
    .o_id(o_id), .o_line_addr(o_line_addr), .o_lane_mask(o_lane_mask),
    .o_word_sel(o_word_sel), .o_retire(o_retire), .o_last(o_last)
`ifdef COALESCE_STAT_EN
    , .o_stat_vecs(o_stat_vecs), .o_stat_lines(o_stat_lines)
`endif
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;
  int exp_vecs = 0;
  int exp_lines = 0;

  logic [AB-1:0] va [VS];

  typedef struct {
    logic [LBW-1:0] line;
    logic [VS-1:0]  mask;
    logic           last;
  } req_t;

  req_t eq[$];

  function automatic logic [AB*VS-1:0] pack_addr();
    logic [AB*VS-1:0] r;
    for (int i = 0; i < VS; i++) r[i*AB +: AB] = va[i];
    return r;
  endfunction

  function automatic logic [LB*VS-1:0] exp_ws();
    logic [LB*VS-1:0] r;
    for (int i = 0; i < VS; i++) r[i*LB +: LB] = va[i][LB-1:0];
    return r;
  endfunction

  function automatic logic [LB*VS-1:0] ws_mask(input logic [VS-1:0] m);
    logic [LB*VS-1:0] r;
    for (int i = 0; i < VS; i++) r[i*LB +: LB] = {LB{m[i]}};
    return r;
  endfunction

  // Group the remaining lanes by line, lowest remaining lane first.
  task automatic build_model(input logic [VS-1:0] valid, input logic retire);
    logic [VS-1:0] rem;
    req_t r;
    int ld;
    eq.delete();
    rem = valid;
    if (valid == '0) begin
      if (retire) begin
        r.line = '0; r.mask = '0; r.last = 1'b1;
        eq.push_back(r);
      end
      return;
    end
    while (rem != '0) begin
      ld = 0;
      while (!rem[ld]) ld++;
      r.line = va[ld] / (1 << LB);
      r.mask = '0;
      for (int i = 0; i < VS; i++)
        if (rem[i] && (va[i] / (1 << LB)) == r.line) r.mask[i] = 1'b1;
      rem = rem & ~r.mask;
      r.last = (rem == '0);
      eq.push_back(r);
    end
  endtask

  task automatic send_vec(input string tag, input logic [VS-1:0] valid, input logic [NB-1:0] id,
                          input logic retire, input bit stall);
    req_t r;
    int guard;
    logic [LB*VS-1:0] wsx, wsm;
    build_model(valid, retire);
    @(negedge i_clk);
    addrval_rdy = 1'b1; i_id = id; i_address = pack_addr(); i_valid = valid; i_retire = retire;
    line_ack = 1'b0;
    #1;
    n_vec++;
    if (addrval_ack !== 1'b1) begin
      n_err++;
      $display("FAIL %s accept: addrval_ack=%b want 1", tag, addrval_ack);
    end
    @(negedge i_clk);
    exp_vecs++;
    addrval_rdy = 1'b0; i_valid = $urandom; i_id = NB'($urandom); i_retire = ~retire;
    wsx = exp_ws();
    guard = 0;
    while (eq.size() > 0 && guard < 200) begin
      r = eq[0];
      guard++;
      line_ack = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      wsm = ws_mask(r.mask);
      n_vec++;
      if (line_rdy !== 1'b1 || o_line_addr !== r.line || o_lane_mask !== r.mask ||
          o_last !== r.last || o_retire !== (retire && r.last) || o_id !== id ||
          (o_word_sel & wsm) !== (wsx & wsm)) begin
        n_err++;
        $display("FAIL %s req: rdy=%b line=%h mask=%h last=%b ret=%b id=%0d want rdy=1 line=%h mask=%h last=%b ret=%b id=%0d",
                 tag, line_rdy, o_line_addr, o_lane_mask, o_last, o_retire, o_id,
                 r.line, r.mask, r.last, retire && r.last, id);
      end
      if (line_ack) begin
        void'(eq.pop_front());
        exp_lines++;
      end
      @(negedge i_clk);
    end
    n_vec++;
    if (guard >= 200) begin
      n_err++;
      $display("FAIL %s timeout: %0d requests outstanding, want 0", tag, eq.size());
    end
    line_ack = 1'b0;
    #1;
    n_vec++;
    if (line_rdy !== 1'b0) begin
      n_err++;
      $display("FAIL %s idle: line_rdy=%b want 0", tag, line_rdy);
    end
  endtask

  task automatic test_reset();
    #1;
    n_vec++;
    if (line_rdy !== 1'b0 || addrval_ack !== 1'b0 || o_id !== '0 || o_lane_mask !== '0 ||
        o_retire !== 1'b0 || o_last !== 1'b0) begin
      n_err++;
      $display("FAIL reset: rdy=%b ack=%b id=%0d mask=%h ret=%b last=%b want all 0",
               line_rdy, addrval_ack, o_id, o_lane_mask, o_retire, o_last);
    end
    @(negedge i_clk);
    i_rst = 1'b1;
  endtask

  task automatic test_contiguous();
    for (int i = 0; i < VS; i++) va[i] = AB'(i);
    send_vec("contig_ret", '1, 3'd1, 1'b1, 1'b0);
    send_vec("contig_noret", '1, 3'd6, 1'b0, 1'b0);
  endtask

  task automatic test_broadcast();
    for (int i = 0; i < VS; i++) va[i] = 32'h40;
    send_vec("broadcast", 32'hFFFF_0000, 3'd2, 1'b0, 1'b0);
  endtask

  task automatic test_empty();
    for (int i = 0; i < VS; i++) va[i] = $urandom;
    send_vec("empty_ret", '0, 3'd5, 1'b1, 1'b0);
    send_vec("empty_noret", '0, 3'd4, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    req_t r;
    for (int i = 0; i < VS; i++) va[i] = 32'h100 + AB'(i);
    build_model('1, 1'b1);
    @(negedge i_clk);
    addrval_rdy = 1'b1; i_id = 3'd3; i_address = pack_addr(); i_valid = '1; i_retire = 1'b1;
    line_ack = 1'b0;
    #1;
    n_vec++;
    if (addrval_ack !== 1'b1) begin
      n_err++;
      $display("FAIL bp accept: addrval_ack=%b want 1", addrval_ack);
    end
    exp_vecs++;
    for (int c = 0; c < 9; c++) begin
      @(negedge i_clk);
      addrval_rdy = (c >= 1 && c <= 5);
      line_ack = !(c >= 1 && c <= 5);
      i_address = {VS{$urandom}};
      i_valid = $urandom;
      #1;
      r = eq[0];
      n_vec++;
      if (line_rdy !== 1'b1 || o_line_addr !== r.line || o_lane_mask !== r.mask ||
          o_last !== r.last || o_retire !== r.last || o_id !== 3'd3) begin
        n_err++;
        $display("FAIL bp req%0d: line=%h mask=%h last=%b ret=%b id=%0d want line=%h mask=%h last=%b",
                 c, o_line_addr, o_lane_mask, o_last, o_retire, o_id, r.line, r.mask, r.last);
      end
      n_vec++;
      if (addrval_rdy && addrval_ack !== 1'b0) begin
        n_err++;
        $display("FAIL bp stall ack: addrval_ack=%b want 0", addrval_ack);
      end
      if (line_ack) begin
        void'(eq.pop_front());
        exp_lines++;
      end
    end
    @(negedge i_clk);
    line_ack = 1'b0;
    #1;
    n_vec++;
    if (line_rdy !== 1'b0 || eq.size() != 0) begin
      n_err++;
      $display("FAIL bp end: line_rdy=%b left=%0d want 0 0", line_rdy, eq.size());
    end
  endtask

  task automatic test_back_to_back();
    req_t q1[$];
    req_t q2[$];
    req_t r;
    logic [NB-1:0] eid;
    for (int i = 0; i < VS; i++) va[i] = 32'h200 + AB'(i % 16);
    build_model('1, 1'b0);
    q1 = eq;
    @(negedge i_clk);
    addrval_rdy = 1'b1; i_id = 3'd1; i_address = pack_addr(); i_valid = '1; i_retire = 1'b0;
    line_ack = 1'b1;
    #1;
    n_vec++;
    if (addrval_ack !== 1'b1) begin
      n_err++;
      $display("FAIL b2b accept1: addrval_ack=%b want 1", addrval_ack);
    end
    for (int i = 0; i < VS; i++) va[i] = (i < 16) ? 32'h400 : 32'h408;
    build_model('1, 1'b1);
    q2 = eq;
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      if (k == 0) begin
        i_id = 3'd2; i_address = pack_addr(); i_valid = '1; i_retire = 1'b1;
      end
      if (k == 2) addrval_rdy = 1'b0;
      #1;
      r = (k < 2) ? q1[k] : q2[k-2];
      eid = (k < 2) ? 3'd1 : 3'd2;
      n_vec++;
      if (line_rdy !== 1'b1 || o_line_addr !== r.line || o_lane_mask !== r.mask ||
          o_last !== r.last || o_retire !== (k == 3) || o_id !== eid) begin
        n_err++;
        $display("FAIL b2b req%0d: rdy=%b line=%h mask=%h last=%b ret=%b id=%0d want line=%h mask=%h last=%b",
                 k, line_rdy, o_line_addr, o_lane_mask, o_last, o_retire, o_id, r.line, r.mask, r.last);
      end
      if (k < 2) begin
        n_vec++;
        if (addrval_ack !== (k == 1)) begin
          n_err++;
          $display("FAIL b2b ack%0d: addrval_ack=%b want %b", k, addrval_ack, k == 1);
        end
      end
    end
    exp_vecs += 2;
    exp_lines += 4;
    @(negedge i_clk);
    line_ack = 1'b0;
    #1;
    n_vec++;
    if (line_rdy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b idle: line_rdy=%b want 0", line_rdy);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < VS; i++) va[i] = 32'h800 + AB'(i);
    @(negedge i_clk);
    addrval_rdy = 1'b1; i_id = 3'd7; i_address = pack_addr(); i_valid = '1; i_retire = 1'b1;
    @(negedge i_clk);
    addrval_rdy = 1'b0;
    line_ack = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    n_vec++;
    if (line_rdy !== 1'b0 || o_lane_mask !== '0 || o_last !== 1'b0 || o_retire !== 1'b0 || o_id !== '0) begin
      n_err++;
      $display("FAIL rst_mid: rdy=%b mask=%h last=%b ret=%b id=%0d want all 0",
               line_rdy, o_lane_mask, o_last, o_retire, o_id);
    end
`ifdef COALESCE_STAT_EN
    n_vec++;
    if (o_stat_vecs !== 16'd0 || o_stat_lines !== 16'd0) begin
      n_err++;
      $display("FAIL rst_stat: vecs=%0d lines=%0d want 0 0", o_stat_vecs, o_stat_lines);
    end
`endif
    exp_vecs = 0;
    exp_lines = 0;
    @(negedge i_clk);
    i_rst = 1'b1;
    line_ack = 1'b1;
    @(negedge i_clk);
    #1;
    n_vec++;
    if (line_rdy !== 1'b0) begin
      n_err++;
      $display("FAIL rst_release: line_rdy=%b want 0", line_rdy);
    end
    line_ack = 1'b0;
    for (int i = 0; i < VS; i++) va[i] = 32'h1000 + AB'($urandom_range(0, 40));
    send_vec("post_reset", $urandom, 3'd2, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    logic [AB-1:0] base;
    logic [VS-1:0] valid;
    for (int n = 0; n < 40; n++) begin
      base = $urandom;
      for (int i = 0; i < VS; i++) va[i] = base + AB'($urandom_range(0, 47));
      case ($urandom_range(0, 7))
        0: valid = '0;
        1: valid = '1;
        2: valid = $urandom & $urandom & $urandom;
        default: valid = $urandom;
      endcase
      send_vec("random", valid, NB'($urandom), 1'($urandom), 1'b1);
    end
  endtask

  task automatic test_stats();
`ifdef COALESCE_STAT_EN
    n_vec++;
    if (o_stat_vecs !== 16'(exp_vecs) || o_stat_lines !== 16'(exp_lines)) begin
      n_err++;
      $display("FAIL stats: vecs=%0d lines=%0d want %0d %0d", o_stat_vecs, o_stat_lines, exp_vecs, exp_lines);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_contiguous();
    test_broadcast();
    test_empty();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_stats();
    test_reset_mid();
    test_stats();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
